// File: rtl/buffer_pkgs.sv
// Shared types for the rename checkpoint store: physical-register sizing,
// the snapshot record and the checkpoint controller state encoding.
package buffer_pkgs;

  localparam int PREGS  = 64;
  localparam int PREG_W = $clog2(PREGS);
  localparam int CNT_W  = $clog2(PREGS) + 1;
  localparam int MAP_W  = 32 * PREG_W;

  typedef struct packed {
    logic [MAP_W-1:0]  map;
    logic [PREG_W-1:0] fl_head;
    logic [PREG_W-1:0] fl_tail;
    logic [CNT_W-1:0]  fl_free_count;
  } ratfl_chkpt_t;

  typedef enum logic {
    CK_IDLE,
    CK_RECOVER
  } ck_state_e;

endpackage

// File: rtl/ratfl_chkpt_cam.sv
// Tag match across valid checkpoint slots. The lowest matching index wins
// the one-hot vector; multi flags a duplicate tag among valid slots.
module ratfl_chkpt_cam #(
  parameter int CHKPT_DEPTH = 4,
  parameter int TAG_W       = 4
) (
  input  logic [CHKPT_DEPTH-1:0]            valid,
  input  logic [CHKPT_DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]                  query,
  output logic [CHKPT_DEPTH-1:0]            hit_vec,
  output logic                              hit,
  output logic                              multi
);

  localparam logic [CHKPT_DEPTH-1:0] ONE = {{(CHKPT_DEPTH-1){1'b0}}, 1'b1};

  logic [CHKPT_DEPTH-1:0] raw;

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHKPT_DEPTH; i++) begin
      raw[i] = valid[i] && (tags[i] == query);
    end
    hit_vec = raw & (~raw + ONE);
    hit     = |raw;
    multi   = |(raw & ~hit_vec);
  end

endmodule

// File: rtl/ratfl_chkpt_ctrl.sv
// Branch checkpoint store for rename RAT/free-list state with one-cycle
// mispredict recovery. Optional sticky err_o when RATFL_CHKPT_ERR_EN is defined.
module ratfl_chkpt_ctrl
  import buffer_pkgs::*;
#(
  parameter int CHKPT_DEPTH = 4,
  parameter int TAG_W       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              chkpt_we_i,
  input  logic [TAG_W-1:0]  chkpt_tag_i,
  input  logic [MAP_W-1:0]  chkpt_rat_map_i,
  input  logic [PREG_W-1:0] chkpt_fl_head_i,
  input  logic [PREG_W-1:0] chkpt_fl_tail_i,
  input  logic [CNT_W-1:0]  chkpt_fl_free_count_i,
  input  logic              br_valid_i,
  input  logic [TAG_W-1:0]  br_tag_i,
  input  logic              br_mispredict_i,
  output logic              chkpt_full_o,
  output logic              rat_recover_o,
  output logic [MAP_W-1:0]  rat_recover_map_o,
  output logic              fl_recover_o,
  output logic [PREG_W-1:0] fl_recover_head_o,
  output logic [PREG_W-1:0] fl_recover_tail_o,
  output logic [CNT_W-1:0]  fl_recover_free_count_o
`ifdef RATFL_CHKPT_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int IDX_W = $clog2(CHKPT_DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(CHKPT_DEPTH);

  ck_state_e                         state_q;
  logic [CHKPT_DEPTH-1:0]            valid_q;
  logic [CHKPT_DEPTH-1:0][TAG_W-1:0] tag_q;
  ratfl_chkpt_t                      data_q [CHKPT_DEPTH];
  logic [IDX_W-1:0]                  head_q;
  logic [IDX_W-1:0]                  tail_q;
  logic [OCC_W-1:0]                  occ_q;
  ratfl_chkpt_t                      rec_q;

  logic [CHKPT_DEPTH-1:0] hit_vec;
  logic                   cam_hit;
  logic                   cam_multi;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       m_age;
  logic [CHKPT_DEPTH-1:0] trim_mask;
  logic [CHKPT_DEPTH-1:0] valid_nxt;
  logic [OCC_W-1:0]       occ_nxt;
  logic                   idle;
  logic                   misp_hit;
  logic                   res_hit;
  logic                   wr_en;
  logic                   adv;

  ratfl_chkpt_cam #(
    .CHKPT_DEPTH (CHKPT_DEPTH),
    .TAG_W       (TAG_W)
  ) u_cam (
    .valid   (valid_q),
    .tags    (tag_q),
    .query   (br_tag_i),
    .hit_vec (hit_vec),
    .hit     (cam_hit),
    .multi   (cam_multi)
  );

  assign chkpt_full_o = (occ_q == FULL_OCC);
  assign idle         = (state_q == CK_IDLE);
  assign misp_hit     = idle && br_valid_i && br_mispredict_i && cam_hit;
  assign res_hit      = idle && br_valid_i && !br_mispredict_i && cam_hit;
  // A write racing a mispredict is younger than the branch, so it is wrong-path.
  assign wr_en        = idle && chkpt_we_i && !chkpt_full_o && !misp_hit;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < CHKPT_DEPTH; i++) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign m_age = hit_idx - head_q;

  // Age relative to head decides which slots are the mispredicted branch or younger.
  always_comb begin
    trim_mask = '0;
    for (int i = 0; i < CHKPT_DEPTH; i++) begin
      trim_mask[i] = (IDX_W'(IDX_W'(i) - head_q) >= m_age);
    end
  end

  always_comb begin
    valid_nxt = valid_q;
    if (res_hit) valid_nxt = valid_nxt & ~hit_vec;
    adv = (occ_q != '0) && !valid_nxt[head_q] && !misp_hit;
    if (wr_en) valid_nxt[tail_q] = 1'b1;
    occ_nxt = occ_q + OCC_W'(wr_en) - OCC_W'(adv);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= CK_IDLE;
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      rat_recover_o <= 1'b0;
      rec_q         <= '0;
    end else begin
      rat_recover_o <= 1'b0;
      if (misp_hit) begin
        state_q       <= CK_RECOVER;
        valid_q       <= valid_q & ~trim_mask;
        tail_q        <= hit_idx;
        occ_q         <= {1'b0, m_age};
        rat_recover_o <= 1'b1;
        rec_q         <= data_q[hit_idx];
      end else begin
        state_q <= CK_IDLE;
        valid_q <= valid_nxt;
        occ_q   <= occ_nxt;
        if (wr_en) tail_q <= tail_q + 1'b1;
        if (adv)   head_q <= head_q + 1'b1;
      end
    end
  end

  // Snapshot payload is not reset; only valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[tail_q]  <= chkpt_tag_i;
      data_q[tail_q] <= '{map:           chkpt_rat_map_i,
                          fl_head:       chkpt_fl_head_i,
                          fl_tail:       chkpt_fl_tail_i,
                          fl_free_count: chkpt_fl_free_count_i};
    end
  end

  assign fl_recover_o            = rat_recover_o;
  assign rat_recover_map_o       = rec_q.map;
  assign fl_recover_head_o       = rec_q.fl_head;
  assign fl_recover_tail_o       = rec_q.fl_tail;
  assign fl_recover_free_count_o = rec_q.fl_free_count;

`ifdef RATFL_CHKPT_ERR_EN
  logic err_evt;

  assign err_evt = idle && ((chkpt_we_i && chkpt_full_o && !misp_hit) ||
                            (br_valid_i && (!cam_hit || cam_multi)));

  always_ff @(posedge clk_i) begin
    if (rst_i)        err_o <= 1'b0;
    else if (err_evt) err_o <= 1'b1;
  end
`else
  logic unused_multi;
  assign unused_multi = cam_multi;
`endif

endmodule

// File: tb/tb_ratfl_chkpt_ctrl.sv
// Scoreboard bench for ratfl_chkpt_ctrl: expected recovery snapshots are queued
// when a mispredict is driven and compared when the recovery pulse appears.
module tb_ratfl_chkpt_ctrl;
  import buffer_pkgs::*;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              chkpt_we;
  logic [TW-1:0]     chkpt_tag;
  logic [MAP_W-1:0]  chkpt_map;
  logic [PREG_W-1:0] chkpt_head;
  logic [PREG_W-1:0] chkpt_tail;
  logic [CNT_W-1:0]  chkpt_cnt;
  logic              br_valid;
  logic [TW-1:0]     br_tag;
  logic              br_misp;
  logic              full;
  logic              rat_rec;
  logic [MAP_W-1:0]  rec_map;
  logic              fl_rec;
  logic [PREG_W-1:0] rec_head;
  logic [PREG_W-1:0] rec_tail;
  logic [CNT_W-1:0]  rec_cnt;
`ifdef RATFL_CHKPT_ERR_EN
  logic              err;
`endif

  int errors = 0;
  int checks = 0;
  ratfl_chkpt_t exp_q[$];
  ratfl_chkpt_t mon_exp;
  ratfl_chkpt_t mon_got;

  ratfl_chkpt_ctrl #(.CHKPT_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .chkpt_we_i              (chkpt_we),
    .chkpt_tag_i             (chkpt_tag),
    .chkpt_rat_map_i         (chkpt_map),
    .chkpt_fl_head_i         (chkpt_head),
    .chkpt_fl_tail_i         (chkpt_tail),
    .chkpt_fl_free_count_i   (chkpt_cnt),
    .br_valid_i              (br_valid),
    .br_tag_i                (br_tag),
    .br_mispredict_i         (br_misp),
    .chkpt_full_o            (full),
    .rat_recover_o           (rat_rec),
    .rat_recover_map_o       (rec_map),
    .fl_recover_o            (fl_rec),
    .fl_recover_head_o       (rec_head),
    .fl_recover_tail_o       (rec_tail),
    .fl_recover_free_count_o (rec_cnt)
`ifdef RATFL_CHKPT_ERR_EN
    ,
    .err_o                   (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic ratfl_chkpt_t mk_snap(input int base, input int hd, input int tl, input int cnt);
    ratfl_chkpt_t s;
    s = '0;
    for (int k = 0; k < 32; k++) s.map[k*PREG_W +: PREG_W] = PREG_W'((k + base) % PREGS);
    s.fl_head       = PREG_W'(hd);
    s.fl_tail       = PREG_W'(tl);
    s.fl_free_count = CNT_W'(cnt);
    return s;
  endfunction

  function automatic ratfl_chkpt_t tag_snap(input int t);
    return mk_snap(t * 3, t + 1, t + 2, t + 10);
  endfunction

  // Scoreboard: every recovery pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rat_rec === 1'b1) begin
      checks++;
      mon_got = '{map: rec_map, fl_head: rec_head, fl_tail: rec_tail, fl_free_count: rec_cnt};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL recover_unexpected: got pulse with head=%0d, expected no pulse", rec_head);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp || fl_rec !== 1'b1) begin
          errors++;
          $display("FAIL recover_data: got %h fl=%b, expected %h fl=1", mon_got, fl_rec, mon_exp);
        end
      end
    end
  end

  task automatic set_idle();
    chkpt_we = 1'b0; chkpt_tag = '0; chkpt_map = '0; chkpt_head = '0;
    chkpt_tail = '0; chkpt_cnt = '0;
    br_valid = 1'b0; br_tag = '0; br_misp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input int tag, input ratfl_chkpt_t s);
    chkpt_we = 1'b1; chkpt_tag = TW'(tag);
    chkpt_map = s.map; chkpt_head = s.fl_head; chkpt_tail = s.fl_tail; chkpt_cnt = s.fl_free_count;
  endtask

  task automatic set_resolve(input int tag, input logic misp);
    br_valid = 1'b1; br_tag = TW'(tag); br_misp = misp;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({full, rat_rec, fl_rec, rec_map, rec_head, rec_tail, rec_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got full=%b rec=%b head=%0d, expected all 0", full, rat_rec, rec_head);
    end
    checks++;
    if (dut.occ_q !== '0) begin errors++; $display("FAIL reset_occ: got %0d, expected 0", dut.occ_q); end
  endtask

  task automatic test_single_mispredict();
    ratfl_chkpt_t s;
    s = mk_snap(32, 5, 9, 28);
    set_write(3, s); tick(); set_idle();
    checks++;
    if (dut.occ_q !== 3'd1 || full !== 1'b0) begin
      errors++; $display("FAIL single_write: got occ=%0d full=%b, expected occ=1 full=0", dut.occ_q, full);
    end
    set_resolve(3, 1'b1);
    exp_q.push_back(s);
    tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b1 || fl_rec !== 1'b1) begin
      errors++; $display("FAIL single_pulse: got rat=%b fl=%b, expected 1 1", rat_rec, fl_rec);
    end
    checks++;
    if (dut.occ_q !== '0) begin errors++; $display("FAIL single_occ: got %0d, expected 0", dut.occ_q); end
    tick();
    checks++;
    if (rat_rec !== 1'b0 || rec_head !== 6'd5 || rec_cnt !== 7'd28) begin
      errors++; $display("FAIL single_hold: got rat=%b head=%0d cnt=%0d, expected 0 5 28", rat_rec, rec_head, rec_cnt);
    end
  endtask

  task automatic test_full();
    for (int t = 1; t <= 4; t++) begin
      set_write(t, tag_snap(t)); tick();
    end
    set_write(5, tag_snap(5)); tick(); set_idle();
    checks++;
    if (full !== 1'b1 || dut.occ_q !== 3'd4) begin
      errors++; $display("FAIL full_set: got full=%b occ=%0d, expected 1 4", full, dut.occ_q);
    end
`ifdef RATFL_CHKPT_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL full_err: got %b, expected 1", err); end
`endif
    set_resolve(1, 1'b0); tick(); set_idle();
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b, expected 0", full); end
    for (int t = 2; t <= 4; t++) begin
      set_resolve(t, 1'b0); tick();
    end
    set_idle(); tick();
    checks++;
    if (dut.occ_q !== '0) begin errors++; $display("FAIL full_drain: got occ=%0d, expected 0", dut.occ_q); end
  endtask

  task automatic test_partial_mispredict();
    for (int t = 1; t <= 3; t++) begin
      set_write(t, tag_snap(t)); tick();
    end
    set_idle();
    set_resolve(2, 1'b1);
    exp_q.push_back(tag_snap(2));
    tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b1 || dut.occ_q !== 3'd1) begin
      errors++; $display("FAIL partial_recover: got rat=%b occ=%0d, expected 1 1", rat_rec, dut.occ_q);
    end
    tick();
    set_resolve(3, 1'b1); tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b0 || dut.occ_q !== 3'd1) begin
      errors++; $display("FAIL partial_trimmed: got rat=%b occ=%0d, expected 0 1", rat_rec, dut.occ_q);
    end
    set_resolve(1, 1'b0); tick(); set_idle(); tick();
    checks++;
    if (dut.occ_q !== '0) begin errors++; $display("FAIL partial_drain: got occ=%0d, expected 0", dut.occ_q); end
  endtask

  task automatic test_out_of_order();
    set_write(5, tag_snap(5)); tick();
    set_write(6, tag_snap(6)); tick(); set_idle();
    set_resolve(6, 1'b0); tick(); set_idle();
    checks++;
    if (dut.occ_q !== 3'd2) begin errors++; $display("FAIL ooo_hold: got occ=%0d, expected 2", dut.occ_q); end
    set_resolve(5, 1'b0); tick(); set_idle(); tick();
    checks++;
    if (dut.occ_q !== '0) begin errors++; $display("FAIL ooo_drain: got occ=%0d, expected 0", dut.occ_q); end
  endtask

  task automatic test_write_vs_mispredict();
    set_write(6, tag_snap(6)); tick(); set_idle();
    set_write(7, tag_snap(7));
    set_resolve(6, 1'b1);
    exp_q.push_back(tag_snap(6));
    tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b1 || dut.occ_q !== '0) begin
      errors++; $display("FAIL wm_recover: got rat=%b occ=%0d, expected 1 0", rat_rec, dut.occ_q);
    end
    set_write(8, tag_snap(8)); tick(); set_idle();
    checks++;
    if (dut.occ_q !== '0 || dut.state_q !== CK_IDLE) begin
      errors++; $display("FAIL wm_recover_write: got occ=%0d state=%0d, expected 0 0", dut.occ_q, dut.state_q);
    end
    set_resolve(7, 1'b1); tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b0) begin errors++; $display("FAIL wm_tag7: got rat=%b, expected 0", rat_rec); end
    set_resolve(8, 1'b1); tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b0) begin errors++; $display("FAIL wm_tag8: got rat=%b, expected 0", rat_rec); end
  endtask

  task automatic test_wrap_reset();
    for (int t = 1; t <= 3; t++) begin
      set_write(t, tag_snap(t)); tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_write(4 + i, tag_snap(4 + i));
      set_resolve(1 + i, 1'b0);
      tick();
      if (i % 3 == 2) begin
        checks++;
        if (dut.occ_q !== 3'd3 || full !== 1'b0) begin
          errors++; $display("FAIL wrap_pair%0d: got occ=%0d full=%b, expected 3 0", i, dut.occ_q, full);
        end
      end
    end
    set_idle();
    set_resolve(10, 1'b1);
    exp_q.push_back(tag_snap(10));
    tick(); set_idle();
    checks++;
    if (rat_rec !== 1'b1 || dut.occ_q !== 3'd1) begin
      errors++; $display("FAIL wrap_recover: got rat=%b occ=%0d, expected 1 1", rat_rec, dut.occ_q);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({full, rat_rec, fl_rec, rec_map, rec_head, rec_tail, rec_cnt} !== '0 ||
        dut.occ_q !== '0 || dut.state_q !== CK_IDLE) begin
      errors++; $display("FAIL wrap_reset: got rec=%b head=%0d occ=%0d state=%0d, expected all 0",
                         rat_rec, rec_head, dut.occ_q, dut.state_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_single_mispredict();
    test_full();
    test_reset();
    test_partial_mispredict();
    test_out_of_order();
    test_write_vs_mispredict();
    test_wrap_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
